sha3_stream_arbiter: RTL and testbench
======================================

# sha3_stream_arbiter

Round-robin AXI-Stream arbiter that shares one SHA3 hashing core (16-bit AXI-Stream message input, digest AXI-Stream output) between NUM_REQ independent message sources. It grants one requester at a time and holds the grant for a whole message through the returned digest. Digest beats are routed back tagged with the requester index. It sits between the per-channel message FIFOs and the single SHA3 core instance.

## Interface
- DATA_WIDTH, 16, message/digest beat width in bits
- NUM_REQ, 4, number of requesters (2..8)
- IDX_W, $clog2(NUM_REQ), requester index width
- TIMEOUT_CYCLES, 4096, digest watchdog limit (used only with SHA3_ARB_TIMEOUT_EN)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low
- s_tdata  in  NUM_REQ*DATA_WIDTH  requester message data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
- s_tuser  in  NUM_REQ*2  SHA variant per port (0=224, 1=256, 2=384, 3=512)
- s_tvalid / s_tlast  in  NUM_REQ each  per-port valid / last message beat
- s_tready  out  NUM_REQ  per-port ready
- m_tdata  out  DATA_WIDTH  message to core
- m_tuser  out  2  SHA variant to core
- m_tvalid / m_tlast  out  1 each  message beat valid / last
- m_tready  in  1  core ready
- r_tdata  in  DATA_WIDTH  digest from core
- r_tvalid / r_tlast  in  1 each  digest beat valid / last
- r_tready  out  1  ready to core
- d_tdata  out  DATA_WIDTH  digest to requesters
- d_tdest  out  IDX_W  owning requester index
- d_tvalid / d_tlast  out  1 each  digest valid / last
- d_tready  in  1  downstream ready
- busy  out  1  grant held
- err  out  1  sticky timeout flag (tied 0 without macro)

## Operation
- States: IDLE, FWD, DIGEST.
- IDLE: if any s_tvalid, pick the first asserted index scanning from (last_grant+1) mod NUM_REQ upward with wrap; register grant, set last_grant=grant, go FWD. No data passes in IDLE.
- FWD: m_tdata/m_tuser/m_tvalid/m_tlast = granted port's signals; s_tready[grant]=m_tready, all other s_tready=0. Beat transfers when s_tvalid[grant]&m_tready. Transfer with s_tlast → DIGEST. A requester dropping tvalid mid-message holds FWD (m_tvalid=0), no re-arbitration.
- DIGEST: d_tdata/d_tvalid/d_tlast = r_*; r_tready=d_tready; d_tdest=grant. Transfer with r_tlast → IDLE. r_tready=0 and d_tvalid=0 in IDLE/FWD (early digest beats stall in core).
- m_tuser passes through unlatched; requester must hold tuser constant per message.
- busy=1 in FWD and DIGEST.

## Timing
- Reset: state=IDLE, last_grant=NUM_REQ-1 (port 0 wins first), grant=0, err=0; all s_tready, m_tvalid, m_tlast, r_tready, d_tvalid, d_tlast, busy =0; m_tdata, d_tdata, d_tdest =0.
- Arbitration latency: request seen in IDLE at edge N → FWD from edge N+1; first beat may transfer in cycle N+1.
- Data paths in FWD/DIGEST are combinational (zero latency); only state/grant registered.
- Last digest beat at edge N → IDLE at N+1; next grant at N+2 earliest. Minimum gap between messages: 1 idle cycle.
- Reset asserted mid-message: return to IDLE next edge, all outputs to reset values, partial message abandoned (core reset by same ARESETn).
- Simultaneous requests: strictly round-robin, no port served twice while another is waiting.

## Configuration
- SHA3_ARB_TIMEOUT_EN defined: counter clears on entering DIGEST and on each digest transfer, increments each DIGEST cycle otherwise; reaching TIMEOUT_CYCLES sets err (sticky until reset) and forces IDLE; subsequent stray digest beats stall in core.
- Not defined: no counter, err tied 0, DIGEST waits indefinitely.

## Test plan
- Single port 2 sends 3 beats (0x1111,0x2222,0x3333 last, tuser=3) → m_* carries same beats, then digest 32 beats emitted with d_tdest=2, last on beat 32; busy drops one cycle after.
- Ports 0,1,3 all valid after reset → grant order 0,1,3,0…; s_tready never high for two ports simultaneously.
- Granted port deasserts tvalid for 5 cycles mid-message → m_tvalid=0 for those 5 cycles, grant unchanged, other valid ports ignored.
- d_tready held 0 for 10 cycles during digest → r_tready=0, d_tdata stable, no beats lost.
- ARESETn low for one cycle mid-FWD → all outputs zero next cycle, port 0 granted first afterwards.
- With SHA3_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, core returns no digest → err=1 after 16 DIGEST cycles, state IDLE, next requester granted.

Source files
------------

// File: rtl/sha3_stream_arbiter.sv
// Round-robin AXI-Stream arbiter sharing one SHA3 core between NUM_REQ message sources.
// Optional digest watchdog is enabled by defining SHA3_ARB_TIMEOUT_EN.
module sha3_stream_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_REQ*2-1:0]          s_tuser,
    input  logic [NUM_REQ-1:0]            s_tvalid,
    input  logic [NUM_REQ-1:0]            s_tlast,
    output logic [NUM_REQ-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic [1:0]                    m_tuser,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    input  logic [DATA_WIDTH-1:0]         r_tdata,
    input  logic                          r_tvalid,
    input  logic                          r_tlast,
    output logic                          r_tready,
    output logic [DATA_WIDTH-1:0]         d_tdata,
    output logic [IDX_W-1:0]              d_tdest,
    output logic                          d_tvalid,
    output logic                          d_tlast,
    input  logic                          d_tready,
    output logic                          busy,
    output logic                          err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FWD    = 2'd1,
        DIGEST = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] grant, grant_nxt;
    logic [IDX_W-1:0] last_grant, last_grant_nxt;
    logic [IDX_W-1:0] rr_pick;
    logic             rr_found;
    logic             m_xfer;
    logic             d_xfer;
    logic             timeout;

    assign m_xfer = s_tvalid[grant] & m_tready;
    assign d_xfer = r_tvalid & d_tready;

    // Scan starts one past the previous winner so a waiting port is never skipped.
    always_comb begin : rr_scan
        int idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rr_found = 1'b0;
        rr_pick  = '0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!rr_found && s_tvalid[IDX_W'(idx)]) begin
                rr_found = 1'b1;
                rr_pick  = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt      = rr_pick;
                    last_grant_nxt = rr_pick;
                    state_nxt      = FWD;
                end
            end
            FWD: begin
                if (m_xfer && s_tlast[grant]) state_nxt = DIGEST;
            end
            DIGEST: begin
                if (d_xfer && r_tlast) state_nxt = IDLE;
                else if (timeout)      state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!ARESETn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

`ifdef SHA3_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    // Fires on the last silent DIGEST cycle, so the grant is dropped after exactly TIMEOUT_CYCLES.
    assign timeout = (state == DIGEST) && !d_xfer && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != DIGEST || d_xfer) wd_cnt <= '0;
            else                           wd_cnt <= wd_cnt + CNT_W'(1);
            if (timeout) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Data paths are purely combinational; outside the owning state everything reads zero.
    always_comb begin
        s_tready = '0;
        m_tdata  = '0;
        m_tuser  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        r_tready = 1'b0;
        d_tdata  = '0;
        d_tdest  = '0;
        d_tvalid = 1'b0;
        d_tlast  = 1'b0;
        case (state)
            FWD: begin
                s_tready[grant] = m_tready;
                m_tdata  = s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                m_tuser  = s_tuser[int'(grant)*2 +: 2];
                m_tvalid = s_tvalid[grant];
                m_tlast  = s_tlast[grant];
            end
            DIGEST: begin
                r_tready = d_tready;
                d_tdata  = r_tdata;
                d_tdest  = grant;
                d_tvalid = r_tvalid;
                d_tlast  = r_tlast;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sha3_stream_arbiter.sv
// Scoreboard bench for sha3_stream_arbiter: per-port sources, a behavioural SHA3 core, and
// expected-beat queues for the message and digest sides.
module tb_sha3_stream_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             ACLK = 1'b0;
    logic             ARESETn;
    logic [NR*DW-1:0] s_tdata;
    logic [NR*2-1:0]  s_tuser;
    logic [NR-1:0]    s_tvalid;
    logic [NR-1:0]    s_tlast;
    logic [NR-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic [1:0]       m_tuser;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;
    logic [DW-1:0]    r_tdata;
    logic             r_tvalid;
    logic             r_tlast;
    logic             r_tready;
    logic [DW-1:0]    d_tdata;
    logic [IW-1:0]    d_tdest;
    logic             d_tvalid;
    logic             d_tlast;
    logic             d_tready;
    logic             busy;
    logic             err;

    always #5 ACLK = ~ACLK;

    sha3_stream_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_W(IW), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tlast(r_tlast), .r_tready(r_tready),
        .d_tdata(d_tdata), .d_tdest(d_tdest), .d_tvalid(d_tvalid), .d_tlast(d_tlast),
        .d_tready(d_tready),
        .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  user;
        logic        last;
        logic [1:0]  port;
    } mbeat_t;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  dest;
        logic        last;
    } dbeat_t;

    typedef struct packed {
        logic [1:0] port;
        logic [1:0] user;
    } creq_t;

    mbeat_t     src_q[NR][$];
    mbeat_t     exp_m[$];
    dbeat_t     exp_d[$];
    creq_t      core_q[$];
    logic [NR-1:0] fire;
    int         hold[NR];
    bit         core_silent;
    bit         core_active;
    bit         last_seen;
    int         d_xfers;
    int         n_vec;
    int         n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int dlen(input logic [1:0] u);
        case (u)
            2'd0:    return 14;
            2'd1:    return 16;
            2'd2:    return 24;
            default: return 32;
        endcase
    endfunction

    task automatic push_msg(input int port, input logic [1:0] user, input int n,
                            input logic [15:0] base, input logic [15:0] step, input bit want);
        mbeat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + step * 16'(i);
            b.user = user;
            b.last = (i == n - 1);
            b.port = 2'(port);
            src_q[port].push_back(b);
            if (want) exp_m.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, 32'(s_tready), 0);
        check({tag, "_m_tvalid"}, 32'(m_tvalid), 0);
        check({tag, "_m_tlast"},  32'(m_tlast), 0);
        check({tag, "_m_tdata"},  32'(m_tdata), 0);
        check({tag, "_r_tready"}, 32'(r_tready), 0);
        check({tag, "_d_tvalid"}, 32'(d_tvalid), 0);
        check({tag, "_d_tlast"},  32'(d_tlast), 0);
        check({tag, "_d_tdata"},  32'(d_tdata), 0);
        check({tag, "_d_tdest"},  32'(d_tdest), 0);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_err"},      32'(err), 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge ACLK); #1;
            done = exp_m.size() == 0 && exp_d.size() == 0 && core_q.size() == 0 &&
                   !core_active && !busy && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                   src_q[2].size() == 0 && src_q[3].size() == 0;
        end
        check({tag, "_drain_timeout"}, 32'(done), 1);
    endtask

    // Source driver: pops a beat after its handshake, then presents the next head.
    initial begin
        mbeat_t h;
        s_tdata  = '0;
        s_tuser  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        forever begin
            @(posedge ACLK); #2;
            for (int k = 0; k < NR; k++) begin
                if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (hold[k] > 0) begin
                    hold[k]--;
                    s_tvalid[k] = 1'b0;
                end else if (src_q[k].size() > 0) begin
                    h = src_q[k][0];
                    s_tvalid[k]          = 1'b1;
                    s_tdata[k*DW +: DW]  = h.data;
                    s_tuser[k*2 +: 2]    = h.user;
                    s_tlast[k]           = h.last;
                end else begin
                    s_tvalid[k] = 1'b0;
                    s_tlast[k]  = 1'b0;
                end
            end
        end
    end

    // Behavioural core: after each full message it returns dlen(user) digest beats.
    initial begin
        creq_t  cq;
        dbeat_t db;
        int     n;
        int     k;
        r_tvalid    = 1'b0;
        r_tlast     = 1'b0;
        r_tdata     = '0;
        core_active = 1'b0;
        forever begin
            @(posedge ACLK); #3;
            if (core_q.size() > 0) begin
                cq = core_q.pop_front();
                if (!core_silent) begin
                    core_active = 1'b1;
                    n = dlen(cq.user);
                    for (int b = 0; b < n; b++) begin
                        r_tdata  = {4'hA, 2'b00, cq.port, 3'b000, 5'(b)};
                        r_tlast  = (b == n - 1);
                        r_tvalid = 1'b1;
                        db.data = r_tdata;
                        db.dest = cq.port;
                        db.last = r_tlast;
                        exp_d.push_back(db);
                        k = 0;
                        while (1) begin
                            @(negedge ACLK);
                            if (r_tready) break;
                            k++;
                            if (k > 500) begin
                                check("r_handshake_timeout", 32'(r_tready), 1);
                                break;
                            end
                        end
                        @(posedge ACLK); #3;
                    end
                    r_tvalid    = 1'b0;
                    r_tlast     = 1'b0;
                    core_active = 1'b0;
                end
            end
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        mbeat_t em;
        dbeat_t ed;
        fire = '0;
        forever begin
            @(negedge ACLK);
            fire = '0;
            if (ARESETn) begin
                check("sready_onehot", 32'($countones(s_tready) <= 1), 1);
                for (int k = 0; k < NR; k++) fire[k] = s_tvalid[k] & s_tready[k];
                if (m_tvalid && m_tready) begin
                    if (exp_m.size() == 0) begin
                        check("m_spurious", 32'(m_tvalid), 0);
                    end else begin
                        em = exp_m.pop_front();
                        check("m_data",  32'(m_tdata), 32'(em.data));
                        check("m_user",  32'(m_tuser), 32'(em.user));
                        check("m_last",  32'(m_tlast), 32'(em.last));
                        check("m_grant", 32'(s_tready[em.port]), 1);
                        if (em.last) core_q.push_back({em.port, em.user});
                    end
                end
                if (last_seen) begin
                    check("busy_drop", 32'(busy), 0);
                    last_seen = 1'b0;
                end
                if (d_tvalid && d_tready) begin
                    if (exp_d.size() == 0) begin
                        check("d_spurious", 32'(d_tvalid), 0);
                    end else begin
                        ed = exp_d.pop_front();
                        d_xfers++;
                        check("d_data", 32'(d_tdata), 32'(ed.data));
                        check("d_dest", 32'(d_tdest), 32'(ed.dest));
                        check("d_last", 32'(d_tlast), 32'(ed.last));
                        if (ed.last) begin
                            check("busy_hold", 32'(busy), 1);
                            last_seen = 1'b1;
                        end
                    end
                end else if (d_tvalid && !d_tready) begin
                    check("d_stall_r_tready", 32'(r_tready), 0);
                    if (exp_d.size() > 0) check("d_stall_data", 32'(d_tdata), 32'(exp_d[0].data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d vectors applied", n_vec);
        $fatal(1, "simulation stopped by watchdog");
    end

    initial begin
        int  cnt;
        int  base;
        bit  ok;
        n_vec       = 0;
        n_err       = 0;
        d_xfers     = 0;
        last_seen   = 1'b0;
        core_silent = 1'b0;
        for (int k = 0; k < NR; k++) hold[k] = 0;
        ARESETn  = 1'b0;
        m_tready = 1'b1;
        d_tready = 1'b1;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs("por");
        @(posedge ACLK); #1;
        ARESETn = 1'b1;

        // Three requesters at once: strict rotation 0,1,3,0,1,3.
        push_msg(0, 2'd0, 2, 16'h0A00, 16'h1, 1'b1);
        push_msg(1, 2'd1, 3, 16'h1A00, 16'h1, 1'b1);
        push_msg(3, 2'd2, 2, 16'h3A00, 16'h1, 1'b1);
        push_msg(0, 2'd3, 1, 16'h0B00, 16'h1, 1'b1);
        push_msg(1, 2'd0, 2, 16'h1B00, 16'h1, 1'b1);
        push_msg(3, 2'd1, 2, 16'h3B00, 16'h1, 1'b1);
        wait_idle("rr", 3000);

        // Single port 2, SHA3-512: 32 digest beats tagged with port 2.
        base = d_xfers;
        push_msg(2, 2'd3, 3, 16'h1111, 16'h1111, 1'b1);
        wait_idle("single", 1000);
        check("single_digest_beats", 32'(d_xfers - base), 32);

        // Granted port pauses 5 cycles while ports 0 and 1 wait.
        push_msg(2, 2'd1, 6, 16'h2000, 16'h1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge ACLK); #1;
            ok = (exp_m.size() <= 4);
        end
        check("stall_reach", 32'(ok), 1);
        hold[2] = 5;
        push_msg(0, 2'd0, 2, 16'h3000, 16'h1, 1'b1);
        push_msg(1, 2'd2, 2, 16'h4000, 16'h1, 1'b1);
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge ACLK);
            if (!m_tvalid) cnt++;
            else break;
        end
        check("stall_len", 32'(cnt), 5);
        wait_idle("stall", 2000);

        // Downstream backpressure for 10 cycles in the middle of a digest.
        base = d_xfers;
        push_msg(3, 2'd0, 2, 16'h5000, 16'h1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge ACLK); #1;
            ok = (d_xfers >= base + 3);
        end
        check("bp_reach", 32'(ok), 1);
        d_tready = 1'b0;
        repeat (10) @(posedge ACLK);
        #1;
        d_tready = 1'b1;
        wait_idle("bp", 1000);
        check("bp_digest_beats", 32'(d_xfers - base), 14);

        // One-cycle reset in the middle of port 1's message; port 0 must win afterwards.
        m_tready = 1'b0;
        push_msg(1, 2'd1, 3, 16'h6000, 16'h1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge ACLK); #1;
            ok = busy;
        end
        check("rst_grant_seen", 32'(ok), 1);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
        src_q[1].delete();
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("midrst");
        @(posedge ACLK); #1;
        push_msg(0, 2'd2, 2, 16'h7000, 16'h1, 1'b1);
        push_msg(2, 2'd0, 2, 16'h7200, 16'h1, 1'b1);
        m_tready = 1'b1;
        wait_idle("midrst", 2000);

`ifdef SHA3_ARB_TIMEOUT_EN
        // Core stays silent: watchdog trips after 16 DIGEST cycles, next requester proceeds.
        core_silent = 1'b1;
        push_msg(1, 2'd2, 2, 16'h8000, 16'h1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge ACLK); #1;
            ok = (exp_m.size() == 0);
        end
        check("to_msg_done", 32'(ok), 1);
        repeat (15) @(posedge ACLK);
        @(negedge ACLK);
        check("to_err_before", 32'(err), 0);
        check("to_busy_before", 32'(busy), 1);
        @(negedge ACLK);
        check("to_err_set", 32'(err), 1);
        check("to_busy_drop", 32'(busy), 0);
        @(posedge ACLK); #1;
        core_silent = 1'b0;
        push_msg(2, 2'd1, 2, 16'h9000, 16'h1, 1'b1);
        wait_idle("to_next", 1000);
        check("to_err_sticky", 32'(err), 1);
`else
        check("err_tied", 32'(err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
